atm_controller_param: RTL

//  Parametrised next-generation ATM controller. Accepts a card, collects a PIN of configurable length
//  and checks it with a configurable retry limit, then runs one transaction: deposit, withdrawal or

---
 rtl/atm_pkg.sv | 17 +
 rtl/atm_if.sv | 39 +++
 rtl/atm_pin_checker.sv | 40 ++++
 rtl/atm_controller_param.sv | 137 +++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared constants for the ATM controller slice:
// FSM state encoding and transaction-type codes.
package atm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ESPERA_TARJETA = 2'd0;
    localparam state_t VERIFICAR_PIN  = 2'd1;
    localparam state_t TRANSACCION    = 2'd2;
    localparam state_t BLOQUEO        = 2'd3;

    localparam logic [1:0] TT_DEP = 2'b00;
    localparam logic [1:0] TT_RET = 2'b01;
    localparam logic [1:0] TT_CON = 2'b10;
    localparam logic [1:0] TT_RSV = 2'b11;

endpackage

// File: rtl/atm_if.sv
// Front-end bundle between keypad/card logic and the
// ATM controller; master is the front end, slave the controller.
interface atm_if #(
    parameter int AMT_W = 32
);
    logic             tarjeta_recibida;
    logic [1:0]       tipo_trans;
    logic             digito_stb;
    logic [3:0]       digito;
    logic             monto_stb;
    logic [AMT_W-1:0] monto;
    logic             balance_actualizado;
    logic             entregar_dinero;
    logic             pin_incorrecto;
    logic             advertencia;
    logic             bloqueo;
    logic             fondos_insuficientes;
    logic             limite_excedido;
    logic             consulta_valida;
    logic [AMT_W-1:0] saldo;

    modport master (
        output tarjeta_recibida, tipo_trans, digito_stb,
        output digito, monto_stb, monto,
        input  balance_actualizado, entregar_dinero,
        input  pin_incorrecto, advertencia, bloqueo,
        input  fondos_insuficientes, limite_excedido,
        input  consulta_valida, saldo
    );

    modport slave (
        input  tarjeta_recibida, tipo_trans, digito_stb,
        input  digito, monto_stb, monto,
        output balance_actualizado, entregar_dinero,
        output pin_incorrecto, advertencia, bloqueo,
        output fondos_insuficientes, limite_excedido,
        output consulta_valida, saldo
    );
endinterface

// File: rtl/atm_pin_checker.sv
// PIN digit collector: shifts digits in and flags the
// outcome combinationally in the cycle the last digit arrives.
module atm_pin_checker #(
    parameter int                        PIN_DIGITS = 4,
    parameter logic [PIN_DIGITS*4-1:0]   PIN_VALUE  = 16'h4756
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       dig_en,
    input  logic [3:0] digito,
    output logic       pin_ok,
    output logic       pin_bad
);
    localparam int W  = PIN_DIGITS * 4;
    localparam int CW = $clog2(PIN_DIGITS + 1);

    logic [W-5:0]  shift;
    logic [W-1:0]  entered;
    logic [CW-1:0] cnt;
    logic          last;

    // Incoming digit completes the code when the counter is on the last slot
    assign entered = {shift, digito};
    assign last    = (cnt == CW'(PIN_DIGITS - 1));
    assign pin_ok  = dig_en && last && (entered == PIN_VALUE);
    assign pin_bad = dig_en && last && (entered != PIN_VALUE);

    // Shift register and digit counter; wrap to 0 after each full code
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shift <= '0;
            cnt   <= '0;
        end else if (dig_en) begin
            shift <= entered[W-5:0];
            cnt   <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/atm_controller_param.sv
// ATM session controller: card -> PIN check with retry
// limit -> one deposit / withdrawal / query, with lock-out.
module atm_controller_param
    import atm_pkg::*;
#(
    parameter int                      PIN_DIGITS = 4,
    parameter logic [PIN_DIGITS*4-1:0] PIN_VALUE  = 16'h4756,
    parameter int                      MAX_TRIES  = 3,
    parameter int                      AMT_W      = 32,
    parameter logic [AMT_W-1:0]        BAL_INIT   = '0,
    parameter logic [AMT_W-1:0]        WD_LIMIT   = 20000
) (
    input logic clk,
    input logic rst,
    atm_if.slave bus
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    state_t           state;
    logic [TW-1:0]    tries;
    logic [TW-1:0]    tries_nxt;
    logic [AMT_W-1:0] saldo;
    logic [AMT_W:0]   dep_sum;
    logic [AMT_W-1:0] dep_sat;
    logic             dig_prev, monto_prev;
    logic             dig_rise, monto_rise;
    logic             pin_ok, pin_bad;
    logic             bal_act, entregar, pin_inc;
    logic             adv, bloq, fondos, limite, consulta;

    assign dig_rise   = bus.digito_stb && !dig_prev;
    assign monto_rise = bus.monto_stb && !monto_prev;
    assign tries_nxt  = tries + TW'(1);
    assign dep_sum    = {1'b0, saldo} + {1'b0, bus.monto};
    assign dep_sat    = dep_sum[AMT_W] ? '1 : dep_sum[AMT_W-1:0];

    atm_pin_checker #(
        .PIN_DIGITS (PIN_DIGITS),
        .PIN_VALUE  (PIN_VALUE)
    ) u_pin (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ESPERA_TARJETA),
        .dig_en  (dig_rise && (state == VERIFICAR_PIN)),
        .digito  (bus.digito),
        .pin_ok  (pin_ok),
        .pin_bad (pin_bad)
    );

    // Session FSM, try counter, balance and registered output flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ESPERA_TARJETA;
            tries      <= '0;
            saldo      <= BAL_INIT;
            dig_prev   <= 1'b0;
            monto_prev <= 1'b0;
            bal_act    <= 1'b0;
            entregar   <= 1'b0;
            pin_inc    <= 1'b0;
            adv        <= 1'b0;
            bloq       <= 1'b0;
            fondos     <= 1'b0;
            limite     <= 1'b0;
            consulta   <= 1'b0;
        end else begin
            dig_prev   <= bus.digito_stb;
            monto_prev <= bus.monto_stb;
            bal_act    <= 1'b0;
            entregar   <= 1'b0;
            pin_inc    <= 1'b0;
            fondos     <= 1'b0;
            limite     <= 1'b0;
            consulta   <= 1'b0;
            unique case (state)
                ESPERA_TARJETA: begin
                    if (bus.tarjeta_recibida)
                        state <= VERIFICAR_PIN;
                end
                VERIFICAR_PIN: begin
                    if (pin_ok) begin
                        state <= TRANSACCION;
                        tries <= '0;
                        adv   <= 1'b0;
                    end else if (pin_bad) begin
                        pin_inc <= 1'b1;
                        tries   <= tries_nxt;
                        if (tries_nxt == TW'(MAX_TRIES)) begin
                            state <= BLOQUEO;
                            bloq  <= 1'b1;
                            adv   <= 1'b0;
                        end else if (tries_nxt == TW'(MAX_TRIES - 1)) begin
                            adv <= 1'b1;
                        end
                    end
                end
                TRANSACCION: begin
                    if (monto_rise) begin
                        state <= ESPERA_TARJETA;
                        unique case (bus.tipo_trans)
                            TT_DEP: begin
                                saldo   <= dep_sat;
                                bal_act <= 1'b1;
                            end
                            TT_RET: begin
                                if (bus.monto > saldo) begin
                                    fondos <= 1'b1;
                                end else if (bus.monto > WD_LIMIT) begin
                                    limite <= 1'b1;
                                end else begin
                                    saldo    <= saldo - bus.monto;
                                    entregar <= 1'b1;
                                    bal_act  <= 1'b1;
                                end
                            end
                            TT_CON: consulta <= 1'b1;
                            TT_RSV: begin
                            end
                        endcase
                    end
                end
                BLOQUEO: bloq <= 1'b1;
            endcase
        end
    end

    assign bus.balance_actualizado  = bal_act;
    assign bus.entregar_dinero      = entregar;
    assign bus.pin_incorrecto       = pin_inc;
    assign bus.advertencia          = adv;
    assign bus.bloqueo              = bloq;
    assign bus.fondos_insuficientes = fondos;
    assign bus.limite_excedido      = limite;
    assign bus.consulta_valida      = consulta;
    assign bus.saldo                = saldo;

endmodule
